// File: rtl/ifetch_prefetch.sv
// Instruction-fetch stage with a prefetch FIFO in front of decode.
// Owns the word-addressed fetch PC, keeps up to MAX_OUTSTANDING requests in
// flight to an in-order instruction memory, and buffers returning words.
// A redirect empties the FIFO and marks every in-flight response as stale.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_BOOT  | first cycle out of reset, no request issued
// ST_RUN   | normal fetch, requests issued while credit and space allow
// ST_FLUSH | redirect taken, dropping stale responses until discard_cnt = 0
module ifetch_prefetch #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DEPTH           = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                  clk1,
    input  logic                  reset1,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [31:0]           imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int NW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = NW + 1;

    localparam logic [CW-1:0]         MAX_OS       = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0]         DISCARD_LAST = CW'(1);
    localparam logic [SW-1:0]         DEPTH_S      = SW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP      = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   fetch_pc;
    logic [ADDR_WIDTH-1:0]   rsp_pc;
    logic [CW-1:0]           outstanding;
    logic [CW-1:0]           discard_cnt;
    logic [NW-1:0]           count;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr;
    logic [31:0]             fifo_instr [DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_pc    [DEPTH];

    logic                    req_fire;
    logic                    drop_rsp;
    logic                    push;
    logic                    pop;
    logic [SW-1:0]           occupancy;
    logic [CW-1:0]           redirect_discard;
    logic [CW-1:0]           outstanding_next;

    // Space is reserved for every in-flight response, so a push can never
    // find the FIFO full.
    assign occupancy        = SW'(count) + SW'(outstanding);
    assign imem_req_valid   = (state == ST_RUN) && !redirect_valid &&
                              (outstanding < MAX_OS) && (occupancy < DEPTH_S);
    assign imem_req_addr    = fetch_pc;

    assign req_fire         = imem_req_valid && imem_req_ready;
    assign drop_rsp         = imem_rsp_valid && (redirect_valid || (discard_cnt != '0));
    assign push             = imem_rsp_valid && !drop_rsp;
    assign pop              = instr_valid && instr_ready && !redirect_valid;

    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    assign redirect_discard = outstanding - CW'(imem_rsp_valid);

    assign instr_valid      = (count != '0);
    assign instr_data       = fifo_instr[rd_ptr];
    assign instr_pc         = fifo_pc[rd_ptr];

    // Fetch control: state, fetch/response PCs and the in-flight counters.
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            state       <= ST_BOOT;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc    <= redirect_pc;
                rsp_pc      <= redirect_pc;
                discard_cnt <= redirect_discard;
                state       <= (redirect_discard != '0) ? ST_FLUSH : ST_RUN;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + PC_STEP;
                end
                if (drop_rsp) begin
                    discard_cnt <= discard_cnt - DISCARD_LAST;
                end
                case (state)
                    ST_BOOT:  state <= ST_RUN;
                    ST_RUN:   state <= ST_RUN;
                    ST_FLUSH: begin
                        if ((discard_cnt == '0) || (drop_rsp && (discard_cnt == DISCARD_LAST))) begin
                            state <= ST_RUN;
                        end
                    end
                    default:  state <= ST_BOOT;
                endcase
            end
        end
    end

    // Prefetch FIFO: storage is cleared on reset so the head reads zero.
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= imem_rsp_data;
                fifo_pc[wr_ptr]    <= rsp_pc;
                wr_ptr             <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
